// File: rtl/phone_chk_pkg.sv
// Shared types, constants and digit-extraction helper for the phone-number digit checker.
package phone_chk_pkg;

  typedef logic [3:0] bcd_digit_t;

  typedef enum logic {
    IDLE,
    COLLECT
  } chk_state_t;

  localparam bcd_digit_t BCD_MAX = 4'd9;

  // Digit k of a packed BCD number; digit 0 is the most significant of the num_digits used.
  function automatic bcd_digit_t get_digit(input logic [63:0] expected,
                                           input int unsigned num_digits,
                                           input int unsigned k);
    logic [63:0] shifted;
    shifted = expected >> (4 * (num_digits - 1 - k));
    return shifted[3:0];
  endfunction

endpackage

// File: rtl/phone_gap_timer.sv
// Idle-gap counter: counts cycles while run is high and flags the TIMEOUT_CYCLES-th one.
// Only instantiated when PHONE_CHK_TIMEOUT_EN is defined.
module phone_gap_timer #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic clear,
  output logic expired
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign expired = run && !clear && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clear || expired) begin
      cnt_d = '0;
    end else if (run) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/phone_digit_checker.sv
// Compares an incoming BCD digit stream against a programmed number; pulses match/error.
// Optional idle-gap timeout enabled by defining PHONE_CHK_TIMEOUT_EN.
module phone_digit_checker
  import phone_chk_pkg::*;
#(
  parameter int                      NUM_DIGITS     = 10,
  parameter logic [4*NUM_DIGITS-1:0] EXPECTED       = 40'h0123456789,
  parameter int                      TIMEOUT_CYCLES = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [3:0]                    digit_in,
  input  logic                          digit_valid,
  output logic                          match,
  output logic                          error,
  output logic                          busy,
  output logic [$clog2(NUM_DIGITS)-1:0] digit_idx,
  output logic [7:0]                    match_count
);

  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
  localparam logic [63:0] EXPECTED_EXT = 64'(EXPECTED);

  if (NUM_DIGITS < 2 || NUM_DIGITS > 16 || TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("phone_digit_checker: parameter out of range");
  end

  chk_state_t       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             match_q, match_d;
  logic             error_q, error_d;
  logic [7:0]       count_q, count_d;
  logic             timeout_expired;
  bcd_digit_t       exp_digit;
  bcd_digit_t       first_digit;

`ifdef PHONE_CHK_TIMEOUT_EN
  phone_gap_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_gap_timer (
    .clk    (clk),
    .rst    (rst),
    .run    (busy && !digit_valid),
    .clear  (digit_valid || !busy),
    .expired(timeout_expired)
  );
`else
  assign timeout_expired = 1'b0;
`endif

  assign exp_digit   = get_digit(EXPECTED_EXT, NUM_DIGITS, int'(idx_q));
  assign first_digit = get_digit(EXPECTED_EXT, NUM_DIGITS, 0);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    idx_d   = idx_q;
    match_d = 1'b0;
    error_d = 1'b0;
    count_d = count_q;
    if (digit_valid) begin
      if (digit_in > BCD_MAX) begin
        error_d = 1'b1;
        idx_d   = '0;
      end else if (digit_in == exp_digit) begin
        if (idx_q == LAST_IDX) begin
          match_d = 1'b1;
          idx_d   = '0;
          if (count_q != 8'hFF) count_d = count_q + 8'd1;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end else begin
        // A wrong digit may itself be the start of a new number.
        error_d = 1'b1;
        idx_d   = (digit_in == first_digit) ? IDX_W'(1) : '0;
      end
    end else if (timeout_expired) begin
      error_d = 1'b1;
      idx_d   = '0;
    end
    state_d = (idx_d == '0) ? IDLE : COLLECT;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      match_q <= 1'b0;
      error_q <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      match_q <= match_d;
      error_q <= error_d;
      count_q <= count_d;
    end
  end

  assign match       = match_q;
  assign error       = error_q;
  assign busy        = (state_q == COLLECT);
  assign digit_idx   = idx_q;
  assign match_count = count_q;

endmodule

// File: tb/tb_phone_digit_checker.sv
// Scoreboard bench for phone_digit_checker: the driver queues hand-computed expectations,
// the monitor compares them one clock edge after each driven cycle.
module tb_phone_digit_checker;

  typedef struct {
    logic       m;
    logic       e;
    logic       b;
    logic [3:0] idx;
    logic [7:0] cnt;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] digit_in = 4'd0;
  logic       digit_valid = 1'b0;
  logic       match;
  logic       error;
  logic       busy;
  logic [3:0] digit_idx;
  logic [7:0] match_count;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  phone_digit_checker dut (
    .clk        (clk),
    .rst        (rst),
    .digit_in   (digit_in),
    .digit_valid(digit_valid),
    .match      (match),
    .error      (error),
    .busy       (busy),
    .digit_idx  (digit_idx),
    .match_count(match_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // Drive one cycle of inputs and queue the outputs expected after the next rising edge.
  task automatic step(input logic r, input logic v, input logic [3:0] d,
                      input int e_idx, input logic e_m, input logic e_e, input int e_cnt);
    exp_t x;
    @(negedge clk);
    rst         = r;
    digit_valid = v;
    digit_in    = d;
    x.m   = e_m;
    x.e   = e_e;
    x.idx = 4'(e_idx);
    x.b   = (e_idx != 0);
    x.cnt = 8'(e_cnt);
    exp_q.push_back(x);
  endtask

  initial begin : monitor
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        check("match", 32'(match), 32'(x.m));
        check("error", 32'(error), 32'(x.e));
        check("busy", 32'(busy), 32'(x.b));
        check("digit_idx", 32'(digit_idx), 32'(x.idx));
        check("match_count", 32'(match_count), 32'(x.cnt));
      end
    end
  end

  initial begin : driver
    int cnt;
    // 1: reset, then a single 0..9 number
    repeat (10) step(1'b1, 1'b0, 4'd0, 0, 1'b0, 1'b0, 0);
    for (int i = 0; i < 10; i++)
      step(1'b0, 1'b1, 4'(i), (i + 1) % 10, i == 9, 1'b0, (i == 9) ? 1 : 0);
    step(1'b0, 1'b0, 4'd0, 0, 1'b0, 1'b0, 1);

    // 2: two back-to-back numbers after a fresh reset
    step(1'b1, 1'b0, 4'd0, 0, 1'b0, 1'b0, 0);
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < 10; i++)
        step(1'b0, 1'b1, 4'(i), (i + 1) % 10, i == 9, 1'b0, (i == 9) ? r + 1 : r);

    // 3: 0,1,0 -> error with the repeated 0 restarting the number, then 1..9 matches
    step(1'b0, 1'b1, 4'd0, 1, 1'b0, 1'b0, 2);
    step(1'b0, 1'b1, 4'd1, 2, 1'b0, 1'b0, 2);
    step(1'b0, 1'b1, 4'd0, 1, 1'b0, 1'b1, 2);
    for (int i = 1; i < 10; i++)
      step(1'b0, 1'b1, 4'(i), (i + 1) % 10, i == 9, 1'b0, (i == 9) ? 3 : 2);

    // 4: non-BCD digit aborts; a following 1 is a mismatch against digit 0
    step(1'b0, 1'b1, 4'd0, 1, 1'b0, 1'b0, 3);
    step(1'b0, 1'b1, 4'd1, 2, 1'b0, 1'b0, 3);
    step(1'b0, 1'b1, 4'd2, 3, 1'b0, 1'b0, 3);
    step(1'b0, 1'b1, 4'hA, 0, 1'b0, 1'b1, 3);
    step(1'b0, 1'b1, 4'd1, 0, 1'b0, 1'b1, 3);
    step(1'b0, 1'b0, 4'd1, 0, 1'b0, 1'b0, 3);

    // 5: reset wins over a valid digit at idx 6
    for (int i = 0; i < 6; i++)
      step(1'b0, 1'b1, 4'(i), i + 1, 1'b0, 1'b0, 3);
    step(1'b1, 1'b1, 4'd6, 0, 1'b0, 1'b0, 0);

    // 6: idle gap after 0,1,2,3
    for (int i = 0; i < 4; i++)
      step(1'b0, 1'b1, 4'(i), i + 1, 1'b0, 1'b0, 0);
`ifdef PHONE_CHK_TIMEOUT_EN
    for (int g = 1; g < 16; g++)
      step(1'b0, 1'b0, 4'd0, 4, 1'b0, 1'b0, 0);
    step(1'b0, 1'b0, 4'd0, 0, 1'b0, 1'b1, 0);
    step(1'b0, 1'b0, 4'd0, 0, 1'b0, 1'b0, 0);
`else
    for (int g = 0; g < 100; g++)
      step(1'b0, 1'b0, 4'd0, 4, 1'b0, 1'b0, 0);
    step(1'b0, 1'b1, 4'd4, 5, 1'b0, 1'b0, 0);
`endif

    // 7: match_count saturates at 255
    step(1'b1, 1'b0, 4'd0, 0, 1'b0, 1'b0, 0);
    for (int r = 0; r < 258; r++)
      for (int i = 0; i < 10; i++) begin
        cnt = (i == 9) ? r + 1 : r;
        if (cnt > 255) cnt = 255;
        step(1'b0, 1'b1, 4'(i), (i + 1) % 10, i == 9, 1'b0, cnt);
      end
    step(1'b0, 1'b0, 4'd0, 0, 1'b0, 1'b0, 255);

    // drain the scoreboard with a bounded wait
    for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(posedge clk);
    #2;
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
